uart_tx: RTL and testbench

Serial transmitter that is the direct upstream peer of UART_RX: it takes a parallel word with a valid strobe and drives one UART frame on `TX_OUT`. The frame is a start bit, then the data bits LSB first, then an optional parity bit, then a stop bit. Each bit is held for `Prescale` clock cycles, so one shared `Prescale` setting gives a cycle-exact loopback into UART_RX.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_bit_timer.sv | 34 +++
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default widths for the UART transmitter.
// The optional parity feature is selected with UART_TX_PARITY_EN; see uart_tx.sv.
package uart_pkg;

    localparam int UART_DATA_WIDTH     = 8;
    localparam int UART_PRESCALE_WIDTH = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..Prescale-1 and pulses bit_done on the last count.
// A prescale of 0 behaves as 1 so every bit still lasts one cycle.
module uart_tx_bit_timer #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] last_cnt;

    assign last_cnt = (prescale == '0) ? '0 : prescale - 1'b1;
    assign bit_done = !clear && (cnt_q == last_cnt);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART frame transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Define UART_TX_PARITY_EN to build the parity bit; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_tx_state_t            state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      timer_clr;
    logic                      bit_done;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    assign timer_clr = (state_q == IDLE);

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_bit_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (timer_clr),
        .prescale(psc_q),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        psc_d   = psc_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
`endif
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    data_d  = P_DATA;
                    psc_d   = Prescale;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = STOP;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) state_d = PARITY;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: if (bit_done) state_d = STOP;
            STOP:   if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Line and busy are registered from the next state so TX_OUT has no input-to-output path.
        busy_d = (state_d != IDLE);
        tx_d   = 1'b1;
        case (state_d)
            START: tx_d = 1'b0;
            DATA:  tx_d = data_d[idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = (^data_d) ^ par_typ_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            psc_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            psc_q   <= psc_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
`endif
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized scoreboard bench for uart_tx: the driver queues expected frames, the monitor checks the line.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       busy;

    always #5 CLK = ~CLK;

    uart_tx dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .TX_OUT    (TX_OUT),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] d;
        bit         pen;
        bit         typ;
        int         psc;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     mon_en   = 1'b1;
    bit     mon_busy = 1'b0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference frame built straight from the frame format rules.
    function automatic void build_bits(input frame_t f, output bit bits[$]);
        bit pen_eff;
`ifdef UART_TX_PARITY_EN
        pen_eff = f.pen;
`else
        pen_eff = 1'b0;
`endif
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(f.d[i]);
        if (pen_eff) bits.push_back((^f.d) ^ f.typ);
        bits.push_back(1'b1);
    endfunction

    initial begin : monitor
        frame_t f;
        bit     bits[$];
        int     per;
        bit     bad;
        forever begin
            @(negedge CLK);
            if (mon_en && busy) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_frame", 1, 0);
                    while (busy) @(negedge CLK);
                end else begin
                    mon_busy = 1'b1;
                    f   = exp_q.pop_front();
                    per = (f.psc == 0) ? 1 : f.psc;
                    build_bits(f, bits);
                    for (int k = 0; k < bits.size(); k++) begin
                        bad = 1'b0;
                        for (int c = 0; c < per; c++) begin
                            if (k > 0 || c > 0) @(negedge CLK);
                            if (TX_OUT !== bits[k] || busy !== 1'b1) bad = 1'b1;
                        end
                        chk(!bad, $sformatf("bit%0d_d%02h", k, f.d), int'(bad), 0);
                    end
                    @(negedge CLK);
                    chk(TX_OUT === 1'b1 && busy === 1'b0, "frame_end_idle",
                        int'({TX_OUT, busy}), 2);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) chk(1'b0, "wait_idle_timeout", n, 0);
    endtask

    task automatic send(input logic [7:0] d, input bit pen, input bit typ,
                        input int psc, input bit push);
        frame_t f;
        wait_idle();
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = typ;
        Prescale   = 6'(psc);
        Data_Valid = 1'b1;
        f.d = d; f.pen = pen; f.typ = typ; f.psc = psc;
        if (push) exp_q.push_back(f);
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        // Scramble inputs mid-frame; the latched values must be unaffected.
        P_DATA   = 8'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        Prescale = 6'($urandom);
    endtask

    initial begin : driver
        frame_t f;
        int     gap;
        int     n;
        RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk(TX_OUT === 1'b1, "reset_tx", int'(TX_OUT), 1);
        chk(busy === 1'b0, "reset_busy", int'(busy), 0);
        RST = 1'b0;

        send(8'b10010110, 1'b1, 1'b0, 8, 1'b1);
        send(8'b10010110, 1'b1, 1'b1, 8, 1'b1);
        send(8'b10101101, 1'b0, 1'b0, 8, 1'b1);

        // Mid-frame pulse must be ignored.
        send(8'h5A, 1'b1, 1'b1, 5, 1'b1);
        repeat (12) @(negedge CLK);
        P_DATA = 8'hFF; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;

        // Held Data_Valid: two frames with exactly one idle cycle between.
        wait_idle();
        P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd4;
        Data_Valid = 1'b1;
        f.d = 8'h96; f.pen = 1'b1; f.typ = 1'b0; f.psc = 4;
        exp_q.push_back(f);
        @(posedge CLK);
        #1;
        P_DATA = 8'h33; PAR_EN = 1'b0; PAR_TYP = 1'b1; Prescale = 6'd3;
        f.d = 8'h33; f.pen = 1'b0; f.typ = 1'b1; f.psc = 3;
        exp_q.push_back(f);
        n = 0;
        while (busy === 1'b1 && n < 200) begin @(negedge CLK); n++; end
        gap = 0;
        while (busy === 1'b0 && gap < 10) begin @(negedge CLK); gap++; end
        Data_Valid = 1'b0;
        chk(gap == 1, "b2b_idle_gap", gap, 1);

        // Reset mid-frame, with a request present on the reset edge.
        wait_idle();
        while (mon_busy) @(negedge CLK);
        mon_en = 1'b0;
        send(8'hC3, 1'b1, 1'b0, 8, 1'b0);
        repeat (29) @(negedge CLK);
        RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h11;
        @(posedge CLK);
        #1;
        chk(TX_OUT === 1'b1, "rst_mid_tx", int'(TX_OUT), 1);
        chk(busy === 1'b0, "rst_mid_busy", int'(busy), 0);
        RST = 1'b0; Data_Valid = 1'b0;
        @(posedge CLK);
        #1;
        chk(busy === 1'b0 && TX_OUT === 1'b1, "rst_req_dropped", int'({TX_OUT, busy}), 2);
        mon_en = 1'b1;
        send(8'h3C, 1'b1, 1'b1, 8, 1'b1);

        // Prescale 0 behaves as 1.
        send(8'hA7, 1'b0, 1'b0, 0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)), 1'b1);
        end

        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
